mcu_sequencer: RTL and testbench

MCU_SEQUENCER -- requirements
Module: mcu_sequencer

---
 rtl/mcu_pkg.sv | 82 ++++++++
 rtl/mcu_if.sv | 41 ++++
 rtl/mcu_decode.sv | 67 ++++++
 rtl/mcu_sequencer.sv | 108 ++++++++++
 tb/tb_mcu_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU sequencer: opcodes (matching the ALU FS encoding),
// FSM states, B-mux codes, instruction field positions and the decoded-control bundle.
package mcu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_R2   = 4'h2;
  localparam logic [3:0] OP_R3   = 4'h3;
  localparam logic [3:0] OP_R4   = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_R7   = 4'h7;
  localparam logic [3:0] OP_IN   = 4'h8;
  localparam logic [3:0] OP_I9   = 4'h9;
  localparam logic [3:0] OP_IA   = 4'hA;
  localparam logic [3:0] OP_BZ   = 4'hB;
  localparam logic [3:0] OP_BNZ  = 4'hC;
  localparam logic [3:0] OP_ST   = 4'hD;
  localparam logic [3:0] OP_MOV  = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  localparam logic [1:0] BSEL_RB  = 2'b00;
  localparam logic [1:0] BSEL_IMM = 2'b01;
  localparam logic [1:0] BSEL_IN  = 2'b10;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RA_HI  = 8;
  localparam int RA_LO  = 6;
  localparam int RB_HI  = 5;
  localparam int RB_LO  = 3;
  localparam int SH_HI  = 2;
  localparam int SH_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB} state_t;

  typedef enum logic [1:0] {BR_NONE, BR_Z, BR_NZ, BR_ALWAYS} br_t;

  typedef struct packed {
    logic [3:0] fs;
    logic [2:0] sh;
    logic [7:0] imm;
    logic [1:0] b_sel;
    logic [2:0] ra_sel;
    logic [2:0] rb_sel;
    logic [2:0] rd_sel;
    logic [7:0] st_addr;
    logic       rf_wr;
    logic       st_wr;
    logic       flag_upd;
    br_t        br;
  } dec_t;

  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [2:0] ir_rd(input logic [15:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

  function automatic logic [2:0] ir_ra(input logic [15:0] ir);
    return ir[RA_HI:RA_LO];
  endfunction

  function automatic logic [2:0] ir_rb(input logic [15:0] ir);
    return ir[RB_HI:RB_LO];
  endfunction

  function automatic logic [2:0] ir_sh(input logic [15:0] ir);
    return ir[SH_HI:SH_LO];
  endfunction

  function automatic logic [7:0] ir_imm(input logic [15:0] ir);
    return ir[IMM_HI:IMM_LO];
  endfunction

endpackage

// File: rtl/mcu_if.sv
// Instruction-memory handshake plus the datapath control/status bus between the
// sequencer (master) and the ALU/register-file side (slave).
interface mcu_if #(parameter int PC_W = 8);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [15:0]     imem_data;

  logic [3:0]      FS;
  logic [2:0]      SH;
  logic [7:0]      imm;
  logic [1:0]      b_sel;
  logic [2:0]      ra_sel;
  logic [2:0]      rb_sel;
  logic [2:0]      rd_sel;
  logic            rf_we;
  logic            st_we;
  logic [7:0]      st_addr;

  logic [7:0]      alu_F;
  logic            alu_N;
  logic            alu_Z;
  logic            alu_C;
  logic            alu_V;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_data,
    output FS, SH, imm, b_sel, ra_sel, rb_sel, rd_sel, rf_we, st_we, st_addr,
    input  alu_F, alu_N, alu_Z, alu_C, alu_V
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_data,
    input  FS, SH, imm, b_sel, ra_sel, rb_sel, rd_sel, rf_we, st_we, st_addr,
    output alu_F, alu_N, alu_Z, alu_C, alu_V
  );

endinterface

// File: rtl/mcu_decode.sv
// Purely combinational instruction decode: IR in, ALU/register-file controls,
// write-enable class and branch class out.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [3:0] op;

  assign op = ir_op(ir);

  always_comb begin
    dec = '0;
    case (op)
      OP_ADD, OP_R2, OP_R3, OP_R4, OP_R7: begin
        dec.fs     = op;
        dec.ra_sel = ir_ra(ir);
        dec.rb_sel = ir_rb(ir);
        dec.b_sel  = BSEL_RB;
        dec.sh     = ir_sh(ir);
        dec.rd_sel = ir_rd(ir);
        dec.rf_wr  = 1'b1;
      end
      // Immediate forms operate in place: rd is both the A source and the destination.
      OP_ADDI, OP_I9, OP_IA: begin
        dec.fs     = op;
        dec.ra_sel = ir_rd(ir);
        dec.b_sel  = BSEL_IMM;
        dec.imm    = ir_imm(ir);
        dec.rd_sel = ir_rd(ir);
        dec.rf_wr  = 1'b1;
      end
      OP_LD: begin
        dec.fs     = OP_LD;
        dec.ra_sel = ir_ra(ir);
        dec.rd_sel = ir_rd(ir);
        dec.rf_wr  = 1'b1;
      end
      OP_IN: begin
        dec.fs     = OP_IN;
        dec.b_sel  = BSEL_IN;
        dec.rd_sel = ir_rd(ir);
        dec.rf_wr  = 1'b1;
      end
      OP_MOV: begin
        dec.fs     = OP_LD;
        dec.ra_sel = ir_ra(ir);
        dec.rd_sel = ir_rd(ir);
        dec.rf_wr  = 1'b1;
      end
      OP_ST: begin
        dec.fs      = OP_ST;
        dec.ra_sel  = ir_rd(ir);
        dec.st_addr = ir_imm(ir);
        dec.st_wr   = 1'b1;
      end
      OP_BZ:   dec.br = BR_Z;
      OP_BNZ:  dec.br = BR_NZ;
      OP_JMP:  dec.br = BR_ALWAYS;
      default: dec = '0;
    endcase
    dec.flag_upd = op inside {OP_ADD, OP_R3, OP_R4, OP_ADDI, OP_R7, OP_I9, OP_IA};
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Multi-cycle MCU control sequencer: fetch/decode/execute/write-back FSM holding
// the program counter, instruction register and {N,Z,C,V} status register.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  mcu_if.master      bus,
  output logic [3:0] flags,
  output logic       busy
);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  dec_t            dec;
  logic            br_take;

  mcu_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  assign bus.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Decoded controls are only exposed from DECODE through WB so the datapath sees
  // a stable instruction for its whole execution and zeros otherwise.
  always_comb begin
    state_nx     = state;
    bus.imem_req = 1'b0;
    bus.FS       = '0;
    bus.SH       = '0;
    bus.imm      = '0;
    bus.b_sel    = '0;
    bus.ra_sel   = '0;
    bus.rb_sel   = '0;
    bus.rd_sel   = '0;
    bus.st_addr  = '0;
    bus.rf_we    = 1'b0;
    bus.st_we    = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_IDLE:   if (run) state_nx = ST_FETCH;
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_valid) state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC:   state_nx = ST_WB;
      ST_WB:     state_nx = run ? ST_FETCH : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (state inside {ST_DECODE, ST_EXEC, ST_WB}) begin
      bus.FS      = dec.fs;
      bus.SH      = dec.sh;
      bus.imm     = dec.imm;
      bus.b_sel   = dec.b_sel;
      bus.ra_sel  = dec.ra_sel;
      bus.rb_sel  = dec.rb_sel;
      bus.rd_sel  = dec.rd_sel;
      bus.st_addr = dec.st_addr;
    end
    if (state == ST_WB) begin
      bus.rf_we = dec.rf_wr;
      bus.st_we = dec.st_wr;
    end
  end

  // Branches test the status register as it stood before this instruction.
  always_comb begin
    br_take = 1'b0;
    case (dec.br)
      BR_Z:      br_take = flags[2];
      BR_NZ:     br_take = ~flags[2];
      BR_ALWAYS: br_take = 1'b1;
      default:   br_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (state == ST_FETCH && bus.imem_valid) begin
      ir <= bus.imem_data;
      pc <= pc + PC_W'(1);
    end else if (state == ST_EXEC && br_take) begin
      pc <= PC_W'(ir_imm(ir));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= '0;
    else if (state == ST_EXEC && dec.flag_upd)
      flags <= {bus.alu_N, bus.alu_Z, bus.alu_C, bus.alu_V};
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: an instruction-timeline model checked every
// cycle, plus directed programs with hand-computed snapshots.
module tb_mcu_sequencer;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] flags;
  logic       busy;

  mcu_if #(.PC_W(8)) bus ();

  mcu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .bus   (bus),
    .flags (flags),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails = 0;
  int rfWeCount = 0;
  int stWeCount = 0;
  int reqCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected control bundle {FS,SH,imm,b_sel,ra_sel,rb_sel,rd_sel,st_addr} for one instruction.
  function automatic logic [33:0] expDecode(input logic [15:0] w);
    logic [3:0] op = w[15:12];
    logic [3:0] fs = '0;
    logic [2:0] sh = '0, ra = '0, rb = '0, rd = '0;
    logic [7:0] im = '0, sa = '0;
    logic [1:0] bs = '0;
    if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h7}) begin
      fs = op; ra = w[8:6]; rb = w[5:3]; sh = w[2:0]; rd = w[11:9];
    end else if (op inside {4'h6, 4'h9, 4'hA}) begin
      fs = op; ra = w[11:9]; bs = 2'b01; im = w[7:0]; rd = w[11:9];
    end else if (op == 4'h5) begin
      fs = op; ra = w[8:6]; rd = w[11:9];
    end else if (op == 4'h8) begin
      fs = op; bs = 2'b10; rd = w[11:9];
    end else if (op == 4'hE) begin
      fs = 4'h5; ra = w[8:6]; rd = w[11:9];
    end else if (op == 4'hD) begin
      fs = op; ra = w[11:9]; sa = w[7:0];
    end
    return {fs, sh, im, bs, ra, rb, rd, sa};
  endfunction

  function automatic bit writesReg(input logic [3:0] op);
    return op inside {[4'h1:4'hA], 4'hE};
  endfunction

  function automatic bit setsFlags(input logic [3:0] op);
    return op inside {4'h1, 4'h3, 4'h4, 4'h6, 4'h7, 4'h9, 4'hA};
  endfunction

  function automatic bit jumps(input logic [3:0] op, input logic z);
    return (op == 4'hB && z) || (op == 4'hC && !z) || (op == 4'hF);
  endfunction

  // Model: an instruction is either being waited for, or in flight with an age of
  // 0/1/2 cycles since capture; flags and branches resolve as age 1 ends.
  logic [7:0]  mPc = 8'h00;
  logic [15:0] mIr = 16'h0000;
  logic [3:0]  mFlags = 4'h0;
  logic        mFetching = 1'b0;
  int          mAge = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPc <= 8'h00; mIr <= '0; mFlags <= '0; mFetching <= 1'b0; mAge <= -1;
    end else if (mAge == 2) begin
      mAge <= -1;
      mFetching <= run;
    end else if (mAge >= 0) begin
      if (mAge == 1) begin
        if (setsFlags(mIr[15:12])) mFlags <= {bus.alu_N, bus.alu_Z, bus.alu_C, bus.alu_V};
        if (jumps(mIr[15:12], mFlags[2])) mPc <= mIr[7:0];
      end
      mAge <= mAge + 1;
    end else if (mFetching) begin
      if (bus.imem_valid) begin
        mIr <= bus.imem_data; mPc <= mPc + 8'd1; mAge <= 0; mFetching <= 1'b0;
      end
    end else begin
      mFetching <= run;
    end
  end

  always @(negedge clk) begin
    checkOutput("ctrl{req,busy,rf_we,st_we}", {bus.imem_req, busy, bus.rf_we, bus.st_we},
                {mFetching, mFetching || mAge >= 0,
                 mAge == 2 && writesReg(mIr[15:12]), mAge == 2 && mIr[15:12] == 4'hD});
    checkOutput("imem_addr", bus.imem_addr, mPc);
    checkOutput("decode_bundle",
                {bus.FS, bus.SH, bus.imm, bus.b_sel, bus.ra_sel, bus.rb_sel, bus.rd_sel, bus.st_addr},
                (mAge >= 0) ? expDecode(mIr) : 34'd0);
    checkOutput("flags", flags, mFlags);
    if (bus.rf_we) rfWeCount++;
    if (bus.st_we) stWeCount++;
    if (bus.imem_req) reqCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  logic [7:0] snapFetchAddr, snapPcDec, snapImm, snapSa;
  logic [3:0] snapFs, snapFlags;
  logic [2:0] snapSh, snapRa, snapRd, snapRf, snapSt;
  logic [1:0] snapBsel;
  int         snapReq;

  // Runs one instruction: waits for FETCH, optionally withholds imem_valid for
  // 'delay' fetch cycles, then snapshots DECODE/EXEC/WB and returns after WB.
  task automatic applyStimulus(input logic [15:0] instr, input int delay,
                               input logic [3:0] nzcv, input bit dropRun);
    int reqStart;
    run = 1'b1;
    bus.imem_data = instr;
    {bus.alu_N, bus.alu_Z, bus.alu_C, bus.alu_V} = nzcv;
    bus.alu_F = 8'h5A;
    bus.imem_valid = (delay == 0);
    reqStart = reqCount;
    for (int i = 0; i < 20 && !bus.imem_req; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("fetch_req_reached", bus.imem_req, 1'b1);
    if (!bus.imem_req) return;
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1 bus.imem_valid = 1'b1;
    end
    @(negedge clk) snapFetchAddr = bus.imem_addr;
    @(posedge clk); #1;
    if (dropRun) run = 1'b0;
    snapReq = reqCount - reqStart;
    @(negedge clk);
    snapFs = bus.FS; snapSh = bus.SH; snapImm = bus.imm; snapBsel = bus.b_sel;
    snapRa = bus.ra_sel; snapRd = bus.rd_sel; snapSa = bus.st_addr; snapPcDec = bus.imem_addr;
    snapRf[2] = bus.rf_we; snapSt[2] = bus.st_we;
    @(negedge clk) begin snapRf[1] = bus.rf_we; snapSt[1] = bus.st_we; end
    @(negedge clk) begin snapRf[0] = bus.rf_we; snapSt[0] = bus.st_we; end
    @(posedge clk); #1;
    snapFlags = flags;
  endtask

  initial begin
    int rfBefore, stBefore;
    bus.imem_valid = 1'b0;
    bus.imem_data = '0;
    bus.alu_F = '0;
    {bus.alu_N, bus.alu_Z, bus.alu_C, bus.alu_V} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_imem_req", bus.imem_req, 1'b0);
    checkOutput("rst_flags", flags, 4'h0);
    checkOutput("rst_fs", bus.FS, 4'h0);
    checkOutput("rst_imem_addr", bus.imem_addr, 8'h00);
    rst = 1'b0;

    applyStimulus(16'h1A50, 0, 4'b0000, 1'b0);
    checkOutput("add_fetch_addr", snapFetchAddr, 8'h00);
    checkOutput("add_rd_sel", snapRd, 3'd5);
    checkOutput("add_fs", snapFs, 4'h1);
    checkOutput("add_ra_sel", snapRa, 3'd1);
    checkOutput("add_rf_we_pattern", snapRf, 3'b001);
    checkOutput("add_pc", snapPcDec, 8'h01);

    applyStimulus(16'h6205, 0, 4'b0100, 1'b0);
    checkOutput("addi_fetch_addr", snapFetchAddr, 8'h01);
    checkOutput("addi_b_sel", snapBsel, 2'b01);
    checkOutput("addi_imm", snapImm, 8'h05);
    checkOutput("addi_ra_sel", snapRa, 3'd1);
    checkOutput("addi_flags", snapFlags, 4'b0100);

    applyStimulus(16'hB040, 0, 4'b0000, 1'b0);
    checkOutput("bz_fetch_addr", snapFetchAddr, 8'h02);
    checkOutput("bz_rf_we_pattern", snapRf, 3'b000);
    checkOutput("bz_flags_kept", snapFlags, 4'b0100);

    applyStimulus(16'h0000, 0, 4'b1111, 1'b0);
    checkOutput("bz_taken_target", snapFetchAddr, 8'h40);
    checkOutput("nop_strobes", {snapRf, snapSt}, 6'b000000);
    checkOutput("nop_flags_kept", snapFlags, 4'b0100);

    applyStimulus(16'h6205, 0, 4'b0000, 1'b0);
    checkOutput("addi2_flags", snapFlags, 4'b0000);
    applyStimulus(16'hB040, 0, 4'b1111, 1'b0);
    checkOutput("bz2_fetch_addr", snapFetchAddr, 8'h42);

    applyStimulus(16'hC080, 0, 4'b0000, 1'b0);
    checkOutput("bz_not_taken_next", snapFetchAddr, 8'h43);
    applyStimulus(16'hF0FF, 0, 4'b0000, 1'b0);
    checkOutput("bnz_taken_target", snapFetchAddr, 8'h80);

    applyStimulus(16'hE4C0, 0, 4'b1111, 1'b0);
    checkOutput("jmp_target", snapFetchAddr, 8'hFF);
    checkOutput("pc_wrap", snapPcDec, 8'h00);
    checkOutput("mov_fs", snapFs, 4'h5);
    checkOutput("mov_ra_rd", {snapRa, snapRd}, {3'd3, 3'd2});
    checkOutput("mov_flags_kept", snapFlags, 4'b0000);

    applyStimulus(16'hD622, 0, 4'b1111, 1'b0);
    checkOutput("st_fetch_addr", snapFetchAddr, 8'h00);
    checkOutput("st_ra_sel", snapRa, 3'd3);
    checkOutput("st_addr", snapSa, 8'h22);
    checkOutput("st_we_pattern", snapSt, 3'b001);
    checkOutput("st_rf_we_pattern", snapRf, 3'b000);
    checkOutput("st_flags_kept", snapFlags, 4'b0000);

    applyStimulus(16'h3A53, 5, 4'b1010, 1'b0);
    checkOutput("slow_req_cycles", snapReq, 6);
    checkOutput("slow_fetch_addr", snapFetchAddr, 8'h01);
    checkOutput("slow_sh", snapSh, 3'd3);
    checkOutput("slow_flags", snapFlags, 4'b1010);

    applyStimulus(16'h8E00, 0, 4'b0000, 1'b1);
    checkOutput("in_b_sel", snapBsel, 2'b10);
    checkOutput("in_rd_sel", snapRd, 3'd7);
    checkOutput("in_rf_we_pattern", snapRf, 3'b001);
    checkOutput("in_flags_kept", snapFlags, 4'b1010);
    checkOutput("run_drop_idle", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 checkOutput("idle_stays", {busy, bus.imem_req}, 2'b00);

    rfBefore = rfWeCount;
    stBefore = stWeCount;
    bus.imem_valid = 1'b0;
    run = 1'b1;
    @(posedge clk); #1;
    checkOutput("pre_rst_fetch_req", bus.imem_req, 1'b1);
    #1 rst = 1'b1;
    #1 checkOutput("rst_in_fetch_outputs", {bus.imem_req, busy, bus.rf_we, bus.st_we}, 4'b0000);
    @(posedge clk); #3 rst = 1'b0;
    applyStimulus(16'h0000, 0, 4'b0000, 1'b0);
    checkOutput("restart_addr_after_fetch_rst", snapFetchAddr, 8'h00);
    checkOutput("no_strobes_after_fetch_rst", {rfWeCount, stWeCount}, {rfBefore, stBefore});

    rfBefore = rfWeCount;
    bus.imem_data = 16'h1A50;
    bus.imem_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    checkOutput("pre_rst_exec_fs", bus.FS, 4'h1);
    rst = 1'b1;
    run = 1'b0;
    #1 checkOutput("rst_in_exec_outputs", {bus.FS, bus.rd_sel, bus.rf_we, busy}, 9'd0);
    @(posedge clk); #3 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("no_rf_we_after_exec_rst", rfWeCount, rfBefore);
    applyStimulus(16'h0000, 0, 4'b0000, 1'b0);
    checkOutput("restart_addr_after_exec_rst", snapFetchAddr, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
